// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit.
// Mode codes and FSM states used by the top and its stepper.
package shift_pkg;

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One partial shift of 0..STEP bits in any of the four modes.
// Pure combinational; the top iterates it until the amount is used up.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SW-1:0]    s,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] rot;

  // low half of the doubled word is the right rotation
  assign rot = WIDTH'({value, value} >> s);

  always_comb begin
    shifted = value;
    unique case (mode)
      MODE_SLL: shifted = value << s;
      MODE_SRL: shifted = value >> s;
      MODE_SRA: shifted = $signed(value) >>> s;
      default:  shifted = rot;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTR, at most STEP bits per clock,
// valid/ready on both sides with same-edge reload from DONE.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(WIDTH),
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  state_t           state;
  logic [AW-1:0]    rem;
  logic [1:0]       mode;
  logic [SW-1:0]    s;
  logic [AW-1:0]    rem_nxt;
  logic [WIDTH-1:0] stepped;
  logic             accept;

  always_comb begin
    s = SW'(STEP);
    if (32'(rem) < STEP) s = SW'(rem);
    rem_nxt = AW'(32'(rem) - 32'(s));
  end

  assign in_ready = (state == IDLE) ||
                    (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .value  (out_data),
    .s      (s),
    .mode   (mode),
    .shifted(stepped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      mode      <= MODE_SLL;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          out_data <= stepped;
          rem      <= rem_nxt;
          if (rem_nxt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_zero  <= (stepped == '0);
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            out_data <= in_data;
            mode     <= in_mode;
            rem      <= in_amt;
            if (in_amt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_zero  <= (in_data == '0);
            end else begin
              state     <= SHIFT;
              out_valid <= 1'b0;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
